// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg: shared pipeline control-word layout and load-size encodings
package mips_pipe_pkg;
    localparam int CTRL_WIDTH     = 18;
    localparam int CS_REG_WRITE   = 0;
    localparam int CS_MEM_TO_REG  = 1;
    localparam int CS_LD_SIZE_LO  = 2;
    localparam int CS_LD_SIZE_HI  = 3;
    localparam int CS_LD_UNSIGNED = 4;
    localparam logic [1:0] LD_BYTE = 2'b00;
    localparam logic [1:0] LD_HALF = 2'b01;
    localparam logic [1:0] LD_WORD = 2'b10;
endpackage

// File: rtl/load_align.sv
// load_align: big-endian byte/half/word extraction with sign/zero extension and misalignment detect
// Ports: i_raw (memory word), i_addr (byte offset), i_size (LD_*), i_unsigned (zero-extend),
//        o_data (extended load value), o_misaligned (half at odd or word at non-zero offset)
module load_align
    import mips_pipe_pkg::*;
(
    input  logic [31:0] i_raw,
    input  logic [1:0]  i_addr,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data,
    output logic        o_misaligned
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    always_comb begin
        w_byte = i_addr == 2'd0 ? i_raw[31:24] :
                 i_addr == 2'd1 ? i_raw[23:16] :
                 i_addr == 2'd2 ? i_raw[15:8]  : i_raw[7:0];
        w_half = i_addr[1] ? i_raw[15:0] : i_raw[31:16];
        // size 11 falls through to the word path
        o_data = i_size == LD_BYTE ? {{24{~i_unsigned & w_byte[7]}}, w_byte} :
                 i_size == LD_HALF ? {{16{~i_unsigned & w_half[15]}}, w_half} : i_raw;
        o_misaligned = (i_size == LD_HALF && i_addr[0]) || (i_size[1] && i_addr != 2'd0);
    end
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register with load alignment, write-back select, stall/flush and retire counter
// Ports: clk/reset (sync, active-high), stall (hold), flush (bubble), EX/MEM inputs
//        (valid_in, control_signals_in, alu_result_in, mem_rdata_in, rd_in) and registered
//        WB outputs (valid_out, control_signals_out, reg_write_out, rd_out, wb_data_out,
//        misaligned_out, retire_count)
module mem_wb_stage #(
    parameter int CTRL_WIDTH = 18,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  valid_in,
    input  logic [CTRL_WIDTH-1:0] control_signals_in,
    input  logic [DATA_WIDTH-1:0] alu_result_in,
    input  logic [DATA_WIDTH-1:0] mem_rdata_in,
    input  logic [4:0]            rd_in,
    output logic                  valid_out,
    output logic [CTRL_WIDTH-1:0] control_signals_out,
    output logic                  reg_write_out,
    output logic [4:0]            rd_out,
    output logic [DATA_WIDTH-1:0] wb_data_out,
    output logic                  misaligned_out,
    output logic [CNT_WIDTH-1:0]  retire_count
);
    import mips_pipe_pkg::*;
    logic                  r_valid;
    logic [CTRL_WIDTH-1:0] r_ctrl;
    logic                  r_reg_write;
    logic [4:0]            r_rd;
    logic [DATA_WIDTH-1:0] r_wb_data;
    logic                  r_misaligned;
    logic [CNT_WIDTH-1:0]  r_retire;
    logic [DATA_WIDTH-1:0] w_load;
    logic                  w_align_mis;
    logic                  w_mem_to_reg;
    logic                  w_mis;
    logic                  w_reg_write;
    logic [DATA_WIDTH-1:0] w_wb_data;
    load_align u_align (
        .i_raw        (mem_rdata_in),
        .i_addr       (alu_result_in[1:0]),
        .i_size       (control_signals_in[CS_LD_SIZE_HI:CS_LD_SIZE_LO]),
        .i_unsigned   (control_signals_in[CS_LD_UNSIGNED]),
        .o_data       (w_load),
        .o_misaligned (w_align_mis)
    );
    always_comb begin
        w_mem_to_reg = control_signals_in[CS_MEM_TO_REG];
        // only memory loads can be misaligned; ALU ops ignore the offset
        w_mis        = w_mem_to_reg & w_align_mis;
        w_wb_data    = w_mem_to_reg ? w_load : alu_result_in;
        w_reg_write  = valid_in & control_signals_in[CS_REG_WRITE] & (rd_in != 5'd0) & ~w_mis;
    end
    always_ff @(posedge clk) begin
        if (reset || flush || (!stall && !valid_in)) begin
            r_valid      <= 1'b0;
            r_ctrl       <= '0;
            r_reg_write  <= 1'b0;
            r_rd         <= '0;
            r_wb_data    <= '0;
            r_misaligned <= 1'b0;
        end else if (!stall) begin
            r_valid      <= 1'b1;
            r_ctrl       <= control_signals_in;
            r_reg_write  <= w_reg_write;
            r_rd         <= rd_in;
            r_wb_data    <= w_wb_data;
            r_misaligned <= w_mis;
        end
        if (reset)
            r_retire <= '0;
        else if (!flush && !stall && valid_in)
            r_retire <= r_retire + 1'b1;
    end
    assign valid_out           = r_valid;
    assign control_signals_out = r_ctrl;
    assign reg_write_out       = r_reg_write;
    assign rd_out              = r_rd;
    assign wb_data_out         = r_wb_data;
    assign misaligned_out      = r_misaligned;
    assign retire_count        = r_retire;
endmodule
